// File: rtl/unidade_hilo_div_pkg.sv
// rtl/unidade_hilo_div_pkg.sv - shared states, widths and ALU opcode decode for the HI/LO divide stage
package unidade_hilo_div_pkg;

    localparam int LARGURA_PADRAO = 32;

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        DIVIDINDO = 2'b01,
        FIM       = 2'b10
    } estado_t;

    localparam logic [4:0] OP_MULTIPLICACAO  = 5'b00010;
    localparam logic [4:0] OP_DIVISAO        = 5'b00011;
    localparam logic [4:0] OP_RESTO_DIVISAO  = 5'b00100;

    // Both divide and remainder opcodes start the same division; HI holds the
    // remainder and LO the quotient, so one run serves either instruction.
    function automatic logic op_inicia_div(input logic [4:0] op);
        return (op == OP_DIVISAO) || (op == OP_RESTO_DIVISAO);
    endfunction

    function automatic logic op_escreve_mult(input logic [4:0] op);
        return (op == OP_MULTIPLICACAO);
    endfunction

endpackage

// File: rtl/unidade_hilo_div_divisor_passo.sv
// rtl/unidade_hilo_div_divisor_passo.sv - one combinational radix-2 restoring division step
//
// Ports:
//   rem      - partial remainder (always below divisor)
//   quo      - dividend bits still to shift in / quotient bits already produced
//   divisor  - divisor magnitude
//   rem_prox - partial remainder after this step
//   quo_prox - quotient/dividend register after this step
module unidade_hilo_div_divisor_passo
    import unidade_hilo_div_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic [LARGURA-1:0] rem,
    input  logic [LARGURA-1:0] quo,
    input  logic [LARGURA-1:0] divisor,
    output logic [LARGURA-1:0] rem_prox,
    output logic [LARGURA-1:0] quo_prox
);

    // Shifting {rem,quo} left can carry one bit past LARGURA, so the trial
    // subtraction is done one bit wider and its MSB is the borrow.
    logic [LARGURA:0] deslocado;
    logic [LARGURA:0] diferenca;

    always_comb begin
        deslocado = {rem, quo[LARGURA-1]};
        diferenca = deslocado - {1'b0, divisor};
        if (diferenca[LARGURA]) begin
            rem_prox = deslocado[LARGURA-1:0];
            quo_prox = {quo[LARGURA-2:0], 1'b0};
        end else begin
            rem_prox = diferenca[LARGURA-1:0];
            quo_prox = {quo[LARGURA-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/unidade_hilo_div.sv
// rtl/unidade_hilo_div.sv - HI/LO registers with multiply load, mthi/mtlo and iterative divider
//
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-low reset
//   inicio, comSinal          - start a division (signed when comSinal), only in OCIOSO
//   dividendo, divisor        - operands, sampled with inicio
//   escreveMult               - load HI/LO from entradaHI/entradaLO
//   mthi, mtlo, dadoMt        - direct HI/LO writes
//   saidaHI, saidaLO          - architectural HI/LO
//   ocupado, pronto, divZero  - busy, one-cycle done pulse, divide-by-zero flag
module unidade_hilo_div
    import unidade_hilo_div_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic               comSinal,
    input  logic [LARGURA-1:0] dividendo,
    input  logic [LARGURA-1:0] divisor,
    input  logic               escreveMult,
    input  logic [LARGURA-1:0] entradaHI,
    input  logic [LARGURA-1:0] entradaLO,
    input  logic               mthi,
    input  logic               mtlo,
    input  logic [LARGURA-1:0] dadoMt,
    output logic [LARGURA-1:0] saidaHI,
    output logic [LARGURA-1:0] saidaLO,
    output logic               ocupado,
    output logic               pronto,
    output logic               divZero
);

    localparam int CONT_W = $clog2(LARGURA);
    localparam logic [CONT_W-1:0] ULTIMO = CONT_W'(LARGURA - 1);

    estado_t             estado_q, estado_d;
    logic [CONT_W-1:0]   contador_q, contador_d;
    logic [LARGURA-1:0]  rem_q, rem_d;
    logic [LARGURA-1:0]  quo_q, quo_d;
    logic [LARGURA-1:0]  div_q, div_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                div_zero_q, div_zero_d;
    logic [LARGURA-1:0]  hi_q, hi_d;
    logic [LARGURA-1:0]  lo_q, lo_d;

    logic [LARGURA-1:0]  rem_prox;
    logic [LARGURA-1:0]  quo_prox;

    unidade_hilo_div_divisor_passo #(
        .LARGURA (LARGURA)
    ) u_passo (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_prox (rem_prox),
        .quo_prox (quo_prox)
    );

    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        // Host writes, lowest priority first so later assignments win:
        // mthi/mtlo < escreveMult < division commit (inside the case below).
        if (estado_q != DIVIDINDO) begin
            if (mthi) hi_d = dadoMt;
            if (mtlo) lo_d = dadoMt;
            if (escreveMult) begin
                hi_d = entradaHI;
                lo_d = entradaLO;
            end
        end

        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    // Work on magnitudes; -2^(N-1) negates to itself, which
                    // is the correct unsigned magnitude.
                    quo_d = (comSinal && dividendo[LARGURA-1]) ? -dividendo : dividendo;
                    div_d = (comSinal && divisor[LARGURA-1])   ? -divisor   : divisor;
                    neg_quo_d  = comSinal && (dividendo[LARGURA-1] ^ divisor[LARGURA-1]);
                    neg_rem_d  = comSinal && dividendo[LARGURA-1];
                    rem_d      = '0;
                    contador_d = '0;
                    div_zero_d = (divisor == '0);
                    if (divisor == '0) begin
                        estado_d = FIM;
                        hi_d     = dividendo;
                        lo_d     = '1;
                    end else begin
                        estado_d = DIVIDINDO;
                    end
                end
            end
            DIVIDINDO: begin
                rem_d      = rem_prox;
                quo_d      = quo_prox;
                contador_d = contador_q + CONT_W'(1);
                if (contador_q == ULTIMO) begin
                    estado_d   = FIM;
                    contador_d = '0;
                    lo_d       = neg_quo_q ? -quo_prox : quo_prox;
                    hi_d       = neg_rem_q ? -rem_prox : rem_prox;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            contador_q <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign saidaHI = hi_q;
    assign saidaLO = lo_q;
    assign ocupado = (estado_q == DIVIDINDO);
    assign pronto  = (estado_q == FIM);
    assign divZero = (estado_q == FIM) && div_zero_q;

endmodule

// File: doc/unidade_hilo_div.md
Name: unidade_hilo_div

Overview:
- Sequential HI/LO register stage directly downstream of the combinational ALU.
- Latches the ALU's 64-bit multiply result ({saidaHI,saidaLO}) into architectural HI/LO registers and serves mfhi/mflo reads.
- Replaces the ALU's single-cycle divide/remainder with an iterative radix-2 restoring divider: 1 quotient bit per cycle, start/busy/done handshake.
- Results land in HI (remainder) and LO (quotient), MIPS-style.

Parameters:
- LARGURA, 32, operand/register width in bits; iteration count equals LARGURA.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
- inicio  input  1  start division; accepted only in state OCIOSO.
- comSinal  input  1  1 = signed division (div), 0 = unsigned (divu); sampled with inicio.
- dividendo  input  LARGURA  dividend (RS), sampled with inicio.
- divisor  input  LARGURA  divisor (RT), sampled with inicio.
- escreveMult  input  1  load HI/LO from ALU multiply outputs.
- entradaHI  input  LARGURA  ALU saidaHI.
- entradaLO  input  LARGURA  ALU saidaLO.
- mthi  input  1  write HI from dadoMt.
- mtlo  input  1  write LO from dadoMt.
- dadoMt  input  LARGURA  data for mthi/mtlo.
- saidaHI  output  LARGURA  HI register.
- saidaLO  output  LARGURA  LO register.
- ocupado  output  1  high while state DIVIDINDO.
- pronto  output  1  one-cycle pulse, division result committed.
- divZero  output  1  valid with pronto; divisor was zero.

Behaviour:
- Reset (reset==0 at an edge): HI=0, LO=0, state OCIOSO, counter=0, ocupado=0, pronto=0, divZero=0. Mid-division reset aborts; no HI/LO write.
- States:
  - OCIOSO: idle.
  - DIVIDINDO: iterating.
  - FIM: one cycle; pronto=1.
- Transitions:
  - OCIOSO + inicio + divisor!=0 -> DIVIDINDO.
  - OCIOSO + inicio + divisor==0 -> FIM.
  - DIVIDINDO with counter==LARGURA-1 -> FIM.
  - FIM -> OCIOSO unconditionally.
- Accept edge E0:
  - Capture |dividendo| and |divisor| (magnitudes if comSinal, else raw).
  - Capture sign flags; clear partial remainder; counter=0.
- Iterations, edges E1..E32:
  - Shift {rem,quo} left 1.
  - Trial-subtract divisor from rem; if no borrow, keep difference and set quo LSB=1.
  - counter increments per edge, wraps never (exits at 31).
- Commit at edge E32 (entry to FIM):
  - LO = quotient, negated if comSinal and signs differ.
  - HI = remainder, negated if comSinal and dividend negative.
  - pronto=1 during cycle after E32. Result visible 32 cycles after E0.
- -2^31 / -1 signed: LO=32'h80000000, HI=0; no trap.
- Divide by zero: at E0 go to FIM; HI=dividendo, LO=32'hFFFFFFFF, divZero=1 alongside pronto. Total latency 1 cycle.
- ocupado=1 exactly in DIVIDINDO (32 cycles). pronto and divZero are 0 outside FIM.
- inicio while not OCIOSO: ignored, no queueing.
- escreveMult/mthi/mtlo:
  - Applied in OCIOSO and FIM (FIM commit wins on the FIM-entry edge).
  - Ignored while ocupado=1.
- Write priority per register, same edge: division commit > escreveMult > mthi/mtlo.
- inicio + escreveMult same edge in OCIOSO: HI/LO take multiply result; division also starts and overwrites at completion.
- Reads are combinational from registers; no bypass of same-cycle writes.

Decomposition:
- Shared package holds:
  - State encodings OCIOSO/DIVIDINDO/FIM.
  - LARGURA default.
  - ALU opcode constants (multiplicacao=5'b00010, divisao=5'b00011, restoDivisao=5'b00100), so decode drives escreveMult/inicio consistently.
- One sub-module, divisor_passo: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once.

Test Plan:
- Reset mid-division: start 100/7 unsigned, pull reset low at iteration 10 -> after edge HI=0, LO=0, ocupado=0, pronto=0; no later pronto.
- Unsigned 100/7: inicio at E0 -> ocupado high 32 cycles; after E32 LO=14, HI=2, pronto pulse 1 cycle, divZero=0.
- Signed -7/2 (32'hFFFFFFF9, 2, comSinal=1) -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). Also 32'h80000000/32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- Divide by zero: dividendo=55, divisor=0 -> next cycle pronto=1, divZero=1, HI=55, LO=32'hFFFFFFFF, ocupado never high.
- Busy lockout: during division assert escreveMult (HI=32'hAAAA, LO=32'h5555), mthi, and a second inicio -> all ignored; final HI/LO equal division result; only one pronto.
- Priority in OCIOSO: escreveMult (HI=1, LO=2) with mthi (dadoMt=9) same edge -> HI=1, LO=2. Then mtlo alone with dadoMt=9 -> LO=9, HI=1.
